load_store_unit: RTL

- Data-memory access stage directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 and funct3 from the decoder.
- Runs a req/ack handshake with data memory and performs byte-lane steering, byte enables, and load sign/zero extension.
- Stalls the core (busy) until the access completes, and flags misaligned, illegal-width and timed-out accesses.

---
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Request fields are held stable by the master until mem_ack.
interface load_store_unit_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   mem_req;
    logic                   mem_we;
    logic [WORD_LENGTH-1:0] mem_addr;
    logic [3:0]             mem_be;
    logic [WORD_LENGTH-1:0] mem_wdata;
    logic                   mem_ack;
    logic [WORD_LENGTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: req/ack handshake with data memory, byte-lane steering,
// byte enables, load extension, and fault reporting (misaligned, bad funct3, timeout).
module load_store_unit #(
    parameter int WORD_LENGTH = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   is_store,
    input  logic [2:0]             funct3,
    input  logic [WORD_LENGTH-1:0] addr,
    input  logic [WORD_LENGTH-1:0] store_data,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] load_data,
    output logic                   fault,
    output logic [1:0]             fault_cause,
    load_store_unit_if.master      mem
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t state, state_nxt;

    logic [CW-1:0]          to_cnt;
    logic                   st_r;
    logic [2:0]             f3_r;
    logic [1:0]             off_r;
    logic [WORD_LENGTH-1:0] addr_r;
    logic [3:0]             be_r;
    logic [WORD_LENGTH-1:0] wdata_r;

    logic                   illegal;
    logic                   misaligned;
    logic                   timeout_hit;
    logic [3:0]             be_nxt;
    logic [WORD_LENGTH-1:0] wdata_nxt;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [WORD_LENGTH-1:0] ld_ext;

    // Request decode on the raw inputs; only meaningful while IDLE with start.
    always_comb begin
        if (is_store) illegal = funct3[2] || (funct3[1:0] == 2'b11);
        else          illegal = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00:   be_nxt = 4'b0001 << addr[1:0];
            2'b01:   be_nxt = 4'b0011 << addr[1:0];
            default: be_nxt = 4'b1111;
        endcase
        wdata_nxt = '0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00:   wdata_nxt = {4{store_data[7:0]}};
                2'b01:   wdata_nxt = {2{store_data[15:0]}};
                default: wdata_nxt = store_data;
            endcase
        end
    end

    // Lane extraction uses the latched offset, since addr may have moved on.
    always_comb begin
        ld_byte = mem.mem_rdata[{off_r, 3'b000} +: 8];
        ld_half = mem.mem_rdata[{off_r[1], 4'b0000} +: 16];
        case (f3_r)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT > 0) && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = (state != IDLE);
        done        = (state == RESP);
        fault       = (state == FAULT);
        mem.mem_req = (state == REQ);
        mem.mem_we  = (state == REQ) && st_r;
        case (state)
            IDLE: begin
                if (start) state_nxt = (illegal || misaligned) ? FAULT : REQ;
            end
            REQ: begin
                // Ack wins over a timeout reached in the same cycle.
                if (mem.mem_ack)      state_nxt = RESP;
                else if (timeout_hit) state_nxt = FAULT;
            end
            RESP:    state_nxt = IDLE;
            FAULT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            st_r        <= 1'b0;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            addr_r      <= '0;
            be_r        <= 4'b0000;
            wdata_r     <= '0;
            load_data   <= '0;
            fault_cause <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (start) begin
                        st_r  <= is_store;
                        f3_r  <= funct3;
                        off_r <= addr[1:0];
                        if (illegal)         fault_cause <= 2'b10;
                        else if (misaligned) fault_cause <= 2'b01;
                        else begin
                            addr_r  <= {addr[WORD_LENGTH-1:2], 2'b00};
                            be_r    <= be_nxt;
                            wdata_r <= wdata_nxt;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        if (!st_r) load_data <= ld_ext;
                    end else if (timeout_hit) begin
                        fault_cause <= 2'b11;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_addr  = addr_r;
    assign mem.mem_be    = be_r;
    assign mem.mem_wdata = wdata_r;
endmodule
